// File: rtl/cmp_pkg.sv
// Shared op-code encoding for the pipelined compare unit and its combinational core.
// Relational ops occupy 001..101; 110/111 are the MIN/MAX operand selects.
package cmp_pkg;

  localparam int CMP_FUN_W = 3;

  typedef logic [CMP_FUN_W-1:0] cmp_fun_t;

  localparam cmp_fun_t CMP_NOP = 3'd0;
  localparam cmp_fun_t CMP_EQ  = 3'd1;
  localparam cmp_fun_t CMP_GT  = 3'd2;
  localparam cmp_fun_t CMP_LT  = 3'd3;
  localparam cmp_fun_t CMP_NE  = 3'd4;
  localparam cmp_fun_t CMP_GE  = 3'd5;
  localparam cmp_fun_t CMP_MIN = 3'd6;
  localparam cmp_fun_t CMP_MAX = 3'd7;

  // True for ops whose result is the boolean outcome zero-extended to DATA_W.
  function automatic logic is_relational(cmp_fun_t fun);
    return (fun != CMP_NOP) && (fun != CMP_MIN) && (fun != CMP_MAX);
  endfunction

endpackage

// File: rtl/cmp_pipe_unit_if.sv
// Operand/result handshake bundle for cmp_pipe_unit: valid/ready on the operand side and on the result side.
// master drives operands and result-ready; slave (the compare unit) drives in_ready and the result.
interface cmp_pipe_unit_if #(
  parameter int DATA_W = 8
);
  import cmp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  cmp_fun_t          cmp_fun;
  logic              signed_mode;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] cmp_out;
  logic              cmp_flag;

  modport master (
    output in_valid, A, B, cmp_fun, signed_mode, out_ready,
    input  in_ready, out_valid, cmp_out, cmp_flag
  );

  modport slave (
    input  in_valid, A, B, cmp_fun, signed_mode, out_ready,
    output in_ready, out_valid, cmp_out, cmp_flag
  );

endinterface

// File: rtl/cmp_core.sv
// Combinational signed/unsigned compare and MIN/MAX select; zero latency, no state, no backpressure.
// EQ/NE ignore signed_mode; MIN/MAX return A when the operands are equal.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  cmp_fun_t          fun,
  input  logic              signed_mode,
  output logic [DATA_W-1:0] value,
  output logic              flag
);

  logic eq;
  logic lt;
  logic gt;
  logic outcome;

  always_comb begin
    eq = (a == b);
    if (signed_mode) begin
      lt = ($signed(a) < $signed(b));
    end else begin
      lt = (a < b);
    end
    gt = !lt && !eq;
  end

  always_comb begin
    outcome = 1'b0;
    unique case (fun)
      CMP_EQ:  outcome = eq;
      CMP_GT:  outcome = gt;
      CMP_LT:  outcome = lt;
      CMP_NE:  outcome = !eq;
      CMP_GE:  outcome = !lt;
      default: outcome = 1'b0;
    endcase
  end

  always_comb begin
    value = '0;
    flag  = 1'b0;
    if (is_relational(fun)) begin
      value = {{(DATA_W-1){1'b0}}, outcome};
      flag  = outcome;
    end else if (fun == CMP_MIN) begin
      value = gt ? b : a;
    end else if (fun == CMP_MAX) begin
      value = lt ? b : a;
    end
  end

endmodule

// File: rtl/cmp_pipe_unit.sv
// Two-stage valid/ready compare pipeline: 2-cycle latency, 1 result/cycle; a stalled result holds both stages.
// Optional saturating hit counter under `define CMP_HIT_CNT_EN; otherwise hit_cnt is tied to 0.
module cmp_pipe_unit
  import cmp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  cmp_pipe_unit_if.slave     bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    cmp_fun_t          fun;
    logic              sgn;
  } s1_t;

  logic              v1;
  logic              v2;
  s1_t               s1;
  logic [DATA_W-1:0] out2;
  logic              flag2;

  logic              adv1;
  logic              adv2;
  logic              in_ready;
  logic              out_hs;

  logic [DATA_W-1:0] core_value;
  logic              core_flag;

  // in_ready looks only at downstream state so it never waits on in_valid.
  assign adv2     = !v2 || bus.out_ready;
  assign adv1     = v1 && adv2;
  assign in_ready = !v1 || adv2;
  assign out_hs   = v2 && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v2;
  assign bus.cmp_out   = out2;
  assign bus.cmp_flag  = flag2;

  cmp_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .a           (s1.a),
    .b           (s1.b),
    .fun         (s1.fun),
    .signed_mode (s1.sgn),
    .value       (core_value),
    .flag        (core_flag)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (in_ready) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1.a   <= bus.A;
        s1.b   <= bus.B;
        s1.fun <= bus.cmp_fun;
        s1.sgn <= bus.signed_mode;
      end
    end
  end

  // An empty S2 slot is loaded with zeros so the result bus reads 0 whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v2    <= 1'b0;
      out2  <= '0;
      flag2 <= 1'b0;
    end else if (adv2) begin
      v2    <= adv1;
      out2  <= adv1 ? core_value : '0;
      flag2 <= adv1 && core_flag;
    end
  end

`ifdef CMP_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (out_hs && flag2 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_clr ^ out_hs;
  assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Directed + randomized bench for cmp_pipe_unit against a transaction-queue reference model.
// Define CMP_HIT_CNT_EN for both bench and RTL to exercise the hit counter.
module tb_cmp_pipe_unit;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
`ifdef CMP_HIT_CNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] hit_cnt;

  always #5 clk = ~clk;

  cmp_pipe_unit_if #(.DATA_W(DATA_W)) bus ();

  cmp_pipe_unit #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .hit_cnt (hit_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        fun;
    logic              sgn;
    int                t;
  } txn_t;

  txn_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_cnt = 0;
  int   acc_total = 0;
  int   drn_total = 0;
  bit   chk_en = 1'b0;

  function automatic int sval(logic [DATA_W-1:0] x, logic sgn);
    int v;
    v = int'(x);
    if (sgn && x[DATA_W-1]) v = v - (1 << DATA_W);
    return v;
  endfunction

  // Returns {flag, value} for one transaction from the operation table.
  function automatic logic [DATA_W:0] ref_res(txn_t e);
    int va;
    int vb;
    logic f;
    logic [DATA_W-1:0] v;
    va = sval(e.a, e.sgn);
    vb = sval(e.b, e.sgn);
    f  = 1'b0;
    v  = '0;
    case (e.fun)
      3'd1: f = (e.a == e.b);
      3'd2: f = (va > vb);
      3'd3: f = (va < vb);
      3'd4: f = (e.a != e.b);
      3'd5: f = (va >= vb);
      3'd6: v = (vb < va) ? e.b : e.a;
      3'd7: v = (vb > va) ? e.b : e.a;
      default: ;
    endcase
    if (e.fun >= 3'd1 && e.fun <= 3'd5) v = f ? DATA_W'(1) : '0;
    return {f, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge: drive inputs, check outputs against the model, advance the model over the posedge.
  task automatic cycle(input bit r, input bit iv, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [2:0] fun, input bit sgn, input bit ordy, input bit clr);
    bit exp_ir;
    bit exp_ov;
    logic [DATA_W:0] r_e;
    txn_t e;
    rst = r;
    bus.in_valid = iv;
    bus.A = a;
    bus.B = b;
    bus.cmp_fun = fun;
    bus.signed_mode = sgn;
    bus.out_ready = ordy;
    cnt_clr = clr;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
    r_e = exp_ov ? ref_res(q[0]) : '0;
    if (chk_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("cmp_out", 32'(bus.cmp_out), 32'(r_e[DATA_W-1:0]));
      chk("cmp_flag", 32'(bus.cmp_flag), 32'(r_e[DATA_W]));
      chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
    end
    if (!r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (HAS_CNT) begin
        if (clr) m_cnt = 0;
        else if (exp_ov && ordy && r_e[DATA_W] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (exp_ov && ordy) begin
        void'(q.pop_front());
        drn_total++;
      end
      if (iv && exp_ir) begin
        e.a = a; e.b = b; e.fun = fun; e.sgn = sgn; e.t = cyc;
        q.push_back(e);
        acc_total++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b1, 1'b0, '0, '0, 3'd0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    int base;
    logic [DATA_W-1:0] ra;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.cmp_fun = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Reset held two cycles with in_valid asserted.
    cycle(1'b0, 1'b1, 8'h12, 8'h12, 3'd1, 1'b0, 1'b1, 1'b0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b1, 8'h12, 8'h12, 3'd1, 1'b0, 1'b1, 1'b0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_cmp_out", 32'(bus.cmp_out), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // GT with 0x80 vs 0x01, signed then unsigned; result valid two cycles after accept.
    cycle(1'b1, 1'b1, 8'h80, 8'h01, 3'd2, 1'b1, 1'b1, 1'b0);
    chk("gt_s_lat1", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    chk("gt_s_valid", 32'(bus.out_valid), 32'd1);
    chk("gt_s_flag", 32'(bus.cmp_flag), 32'd0);
    chk("gt_s_out", 32'(bus.cmp_out), 32'h00);
    cycle(1'b1, 1'b1, 8'h80, 8'h01, 3'd2, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("gt_u_flag", 32'(bus.cmp_flag), 32'd1);
    chk("gt_u_out", 32'(bus.cmp_out), 32'h01);

    // MIN/MAX selects.
    cycle(1'b1, 1'b1, 8'hFF, 8'h02, 3'd6, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 8'h02, 3'd6, 1'b0, 1'b1, 1'b0);
    chk("min_s_out", 32'(bus.cmp_out), 32'hFF);
    cycle(1'b1, 1'b1, 8'h55, 8'h55, 3'd7, 1'b1, 1'b1, 1'b0);
    chk("min_u_out", 32'(bus.cmp_out), 32'h02);
    idle(1'b1);
    chk("max_eq_out", 32'(bus.cmp_out), 32'h55);
    chk("max_eq_flag", 32'(bus.cmp_flag), 32'd0);
    idle(1'b1);

    // Eight back-to-back EQ ops with out_ready held high.
    base = drn_total;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, DATA_W'(i * 3), DATA_W'((i % 2 == 0) ? i * 3 : i * 3 + 1), 3'd1, 1'b0, 1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    chk("stream_results", 32'(drn_total - base), 32'd8);

    // Five stalled cycles under a continuous stream: only two entries get in.
    base = acc_total;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, DATA_W'($urandom), DATA_W'($urandom), 3'($urandom_range(1, 7)), 1'($urandom), 1'b0, 1'b0);
    end
    chk("stall_accepts", 32'(acc_total - base), 32'd2);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    base = drn_total;
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("stall_drain", 32'(drn_total - base), 32'd2);

    // Hit counter: saturation, then clear racing a hit.
    cycle(1'b1, 1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'h3C, 8'h3C, 3'd1, 1'($urandom), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
`ifdef CMP_HIT_CNT_EN
    chk("hit_saturate", 32'(hit_cnt), 32'd3);
`else
    chk("hit_tied_zero", 32'(hit_cnt), 32'd0);
`endif
    cycle(1'b1, 1'b1, 8'hA5, 8'hA5, 3'd1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("clr_race_flag", 32'(bus.cmp_flag), 32'd1);
    cycle(1'b1, 1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1);
    chk("clr_race_cnt", 32'(hit_cnt), 32'd0);

    // Reset with two entries in flight drops both.
    cycle(1'b1, 1'b1, 8'h01, 8'h01, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h02, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    idle(1'b1);
    chk("midrst_no_emit", 32'(bus.out_valid), 32'd0);

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      ra = DATA_W'($urandom);
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), ra,
            ($urandom_range(0, 3) == 0) ? ra : DATA_W'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
